// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl
//
// Purpose:
//   Time-multiplexed scan controller for a multi-digit seven-segment display.
//   A single shared BCD-to-seven-segment decoder is driven with one nibble at a
//   time while a one-hot digit enable lights the matching digit. New values are
//   staged in a pending register and copied into the display register only at
//   frame start, so a frame never mixes old and new digits. Optional
//   leading-zero blanking hides zero digits above the most significant nonzero
//   digit. Digit 0 always stays lit.
//
// Parameters:
//   NUM_DIGITS   - number of multiplexed digits (2..8)
//   REFRESH_DIV  - clock cycles each digit is lit (>= 1)
//   BLANK_CYCLES - all-off cycles between digits to avoid ghosting (0 = none)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   scan enable; low forces IDLE (blank) on the next edge
//   load       in   capture request for bcd_in
//   bcd_in     in   packed BCD digits, digit 0 in bits [3:0]
//   lz_en      in   leading-zero suppression enable
//   bcd_out    out  nibble to the shared decoder, 4'hF = blank
//   digit_sel  out  one-hot active-high digit enable
//   frame_done out  one-cycle pulse with the first cycle of digit 0 after a wrap
//   pending    out  a loaded value is waiting to be applied
//
// Handshake / timing:
//   There is no ready path: load is accepted on every edge where it is high.
//   All outputs are registered and change on the same edge as state/idx.
// -----------------------------------------------------------------------------
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lz_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Registered state
  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] pend_val;

  // Next-state values
  state_t                  state_n;
  logic [IDX_W-1:0]        idx_n;
  logic [CNT_W-1:0]        cnt_n;
  logic [4*NUM_DIGITS-1:0] disp_n;
  logic [4*NUM_DIGITS-1:0] pend_val_n;
  logic                    pending_n;
  logic                    frame_done_n;
  logic                    show_n;     // next cycle lights digit idx_n (unless suppressed)
  logic                    advance;    // move to the next digit this edge
  logic                    apply;      // copy staged value into the display register

  // Output decode
  logic [NUM_DIGITS-1:0]   supp;       // per-digit leading-zero suppression of disp_n
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   digit_sel_n;
  logic [3:0]              bcd_out_n;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      disp       <= '0;
      pend_val   <= '0;
      pending    <= 1'b0;
      digit_sel  <= '0;
      bcd_out    <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      disp       <= disp_n;
      pend_val   <= pend_val_n;
      pending    <= pending_n;
      digit_sel  <= digit_sel_n;
      bcd_out    <= bcd_out_n;
      frame_done <= frame_done_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    disp_n       = disp;
    pend_val_n   = pend_val;
    pending_n    = pending;
    frame_done_n = 1'b0;
    show_n       = 1'b0;
    advance      = 1'b0;
    apply        = 1'b0;

    // Capture is independent of the scan; an apply below overrides pending.
    if (load) begin
      pend_val_n = bcd_in;
      pending_n  = 1'b1;
    end

    if (!en) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = SCAN;
          idx_n   = '0;
          cnt_n   = '0;
          apply   = 1'b1;
          show_n  = 1'b1;
        end

        SCAN: begin
          if (cnt == REFRESH_LAST) begin
            cnt_n = '0;
            if (BLANK_CYCLES > 0) begin
              state_n = BLANK;
            end else begin
              advance = 1'b1;
              show_n  = 1'b1;
            end
          end else begin
            cnt_n  = cnt + CNT_W'(1);
            show_n = 1'b1;
          end
        end

        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt_n   = '0;
            state_n = SCAN;
            advance = 1'b1;
            show_n  = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end

    // Wrapping back to digit 0 is a frame boundary: signal it and apply.
    if (advance) begin
      if (idx == IDX_LAST) begin
        idx_n        = '0;
        frame_done_n = 1'b1;
        apply        = 1'b1;
      end else begin
        idx_n = idx + IDX_W'(1);
      end
    end

    // A load coinciding with the apply bypasses the pending register.
    if (apply) begin
      if (load) begin
        disp_n = bcd_in;
      end else if (pending) begin
        disp_n = pend_val;
      end
      pending_n = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero mask, evaluated on the display value that will be shown.
  // Walk from the most significant digit down; a digit is suppressed while it
  // and everything above it are zero. Digit 0 is never suppressed.
  // ---------------------------------------------------------------------------
  always_comb begin
    supp     = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (disp_n[4*i +: 4] == 4'h0);
      supp[i]  = lz_en && all_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered in the state register block)
  // ---------------------------------------------------------------------------
  always_comb begin
    digit_sel_n = '0;
    bcd_out_n   = 4'hF;
    if (show_n && !supp[idx_n]) begin
      digit_sel_n = NUM_DIGITS'(1) << idx_n;
      bcd_out_n   = disp_n[{idx_n, 2'b00} +: 4];
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_ctrl
//
// Directed bench for sseg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=4.
// dut uses BLANK_CYCLES=1 (20-cycle frame), dut0 uses BLANK_CYCLES=0
// (16-cycle frame). Both share the same inputs.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, so each sample reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst, en, load, lz_en;
  logic [15:0] bcd_in;

  logic [3:0]  bcd_out, bcd_out0;
  logic [3:0]  digit_sel, digit_sel0;
  logic        frame_done, frame_done0;
  logic        pending, pending0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in), .lz_en(lz_en),
    .bcd_out(bcd_out), .digit_sel(digit_sel), .frame_done(frame_done), .pending(pending)
  );

  sseg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in), .lz_en(lz_en),
    .bcd_out(bcd_out0), .digit_sel(digit_sel0), .frame_done(frame_done0), .pending(pending0)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and helpers
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] sel, input logic [3:0] bcd,
                         input logic fd, input logic pend);
    chk({tag, " sel"},  {28'd0, digit_sel},  {28'd0, sel});
    chk({tag, " bcd"},  {28'd0, bcd_out},    {28'd0, bcd});
    chk({tag, " fd"},   {31'd0, frame_done}, {31'd0, fd});
    chk({tag, " pend"}, {31'd0, pending},    {31'd0, pend});
  endtask

  task automatic chk_out0(input string tag, input logic [3:0] sel, input logic [3:0] bcd,
                          input logic fd, input logic pend);
    chk({tag, " sel0"},  {28'd0, digit_sel0},  {28'd0, sel});
    chk({tag, " bcd0"},  {28'd0, bcd_out0},    {28'd0, bcd});
    chk({tag, " fd0"},   {31'd0, frame_done0}, {31'd0, fd});
    chk({tag, " pend0"}, {31'd0, pending0},    {31'd0, pend});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Frame vectors: value shown in the frame, lz_en during it, and the expected
  // digit_sel / bcd_out per digit (digit d in bits [4d+3:4d]).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] val;
    logic        lz;
    logic [15:0] sel;
    logic [15:0] bcd;
  } frame_vec_t;

  frame_vec_t vecs[7];

  // Checks one 20-cycle frame starting at the first cycle of digit 0.
  // A load of nxt_val is strobed while digit 2 is lit; it must stay pending
  // until the wrap edge that ends this task.
  task automatic run_frame(input int fi, input frame_vec_t v, input logic fd0,
                           input logic [15:0] nxt_val, input logic nxt_lz);
    int          d, p;
    logic [3:0]  e_sel, e_bcd;
    for (int k = 0; k < 20; k++) begin
      d = k / 5;
      p = k % 5;
      e_sel = (p < 4) ? v.sel[4*d +: 4] : 4'h0;
      e_bcd = (p < 4) ? v.bcd[4*d +: 4] : 4'hF;
      chk_out($sformatf("frame%0d k%0d", fi, k), e_sel, e_bcd, (k == 0) ? fd0 : 1'b0, (k >= 13));
      load = (k == 12);
      if (k == 12) bcd_in = nxt_val;
      if (k == 19) lz_en = nxt_lz;
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] v6;
    int          d;
    logic [15:0] nv;
    logic        nlz;

    vecs[0] = '{val: 16'h1234, lz: 1'b0, sel: 16'h8421, bcd: 16'h1234};
    vecs[1] = '{val: 16'h9876, lz: 1'b0, sel: 16'h8421, bcd: 16'h9876};
    vecs[2] = '{val: 16'h0050, lz: 1'b1, sel: 16'h0021, bcd: 16'hFF50};
    vecs[3] = '{val: 16'h0000, lz: 1'b1, sel: 16'h0001, bcd: 16'hFFF0};
    vecs[4] = '{val: 16'h0A07, lz: 1'b1, sel: 16'h0421, bcd: 16'hFA07};
    vecs[5] = '{val: 16'h8000, lz: 1'b1, sel: 16'h8421, bcd: 16'h8000};
    vecs[6] = '{val: 16'h0000, lz: 1'b0, sel: 16'h8421, bcd: 16'h0000};

    rst    = 1'b1;
    en     = 1'b0;
    load   = 1'b0;
    lz_en  = 1'b0;
    bcd_in = 16'h0;
    tick();
    tick();
    chk_out("reset", 4'h0, 4'hF, 1'b0, 1'b0);
    chk_out0("reset", 4'h0, 4'hF, 1'b0, 1'b0);

    // Load while idle: staged only.
    rst    = 1'b0;
    load   = 1'b1;
    bcd_in = vecs[0].val;
    lz_en  = vecs[0].lz;
    tick();
    load = 1'b0;
    chk_out("idle load", 4'h0, 4'hF, 1'b0, 1'b1);

    // Start scanning; IDLE->SCAN applies the staged value.
    en = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      nv  = (i < 6) ? vecs[i+1].val : 16'h5555;
      nlz = (i < 6) ? vecs[i+1].lz  : 1'b0;
      run_frame(i, vecs[i], (i != 0), nv, nlz);
    end

    // Two loads in one frame: last one wins.
    chk_out("ll k0", 4'h1, 4'h5, 1'b1, 1'b0);
    load   = 1'b1;
    bcd_in = 16'h1111;
    tick();
    load = 1'b0;
    chk_out("ll k1", 4'h1, 4'h5, 1'b0, 1'b1);
    repeat (4) tick();
    chk_out("ll k5", 4'h2, 4'h5, 1'b0, 1'b1);
    load   = 1'b1;
    bcd_in = 16'h2222;
    tick();
    load = 1'b0;
    chk_out("ll k6", 4'h2, 4'h5, 1'b0, 1'b1);
    repeat (14) tick();
    chk_out("ll apply", 4'h1, 4'h2, 1'b1, 1'b0);

    // Load landing exactly on the apply edge goes straight to the display.
    repeat (19) tick();
    chk_out("la k19", 4'h0, 4'hF, 1'b0, 1'b0);
    load   = 1'b1;
    bcd_in = 16'h3456;
    tick();
    load = 1'b0;
    chk_out("la k0", 4'h1, 4'h6, 1'b1, 1'b0);
    tick();
    chk_out("la k1", 4'h1, 4'h6, 1'b0, 1'b0);

    // Drop en during digit 1 with a value pending; it must survive IDLE.
    repeat (4) tick();
    chk_out("en k5", 4'h2, 4'h5, 1'b0, 1'b0);
    load   = 1'b1;
    bcd_in = 16'h7777;
    tick();
    load = 1'b0;
    chk_out("en k6", 4'h2, 4'h5, 1'b0, 1'b1);
    en = 1'b0;
    tick();
    chk_out("en off1", 4'h0, 4'hF, 1'b0, 1'b1);
    tick();
    chk_out("en off2", 4'h0, 4'hF, 1'b0, 1'b1);
    en = 1'b1;
    tick();
    chk_out("en on k0", 4'h1, 4'h7, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_out($sformatf("en on k%0d", k), 4'h1, 4'h7, 1'b0, 1'b0);
    end
    tick();
    chk_out("en on k4", 4'h0, 4'hF, 1'b0, 1'b0);
    tick();
    chk_out("en on k5", 4'h2, 4'h7, 1'b0, 1'b0);

    // Reset mid-frame drops the pending value and clears the display.
    load   = 1'b1;
    bcd_in = 16'h4321;
    tick();
    load = 1'b0;
    chk_out("rst pre", 4'h2, 4'h7, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    chk_out("rst mid", 4'h0, 4'hF, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("rst restart", 4'h1, 4'h0, 1'b0, 1'b0);

    // No-blank build: back-to-back digits, 16-cycle frame, hex nibble passes.
    rst = 1'b1;
    en  = 1'b0;
    tick();
    chk_out0("rst0", 4'h0, 4'hF, 1'b0, 1'b0);
    rst    = 1'b0;
    en     = 1'b1;
    lz_en  = 1'b0;
    load   = 1'b1;
    v6     = 16'h3A21;
    bcd_in = v6;
    tick();
    load = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      d = (k % 16) / 4;
      chk_out0($sformatf("nb k%0d", k), 4'h1 << d, v6[4*d +: 4],
               (k == 16) || (k == 32), 1'b0);
      if (k < 32) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit seven-segment display.
- Sequences one shared BCD-to-seven-segment decoder across NUM_DIGITS digits and drives one-hot digit enables.
- Holds a tear-free display register and supports optional leading-zero blanking.
- Sits between the value producer (counter/FSM logic) and the decoder plus the digit anode drivers.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 50000, clock cycles each digit is lit; must be >= 1.
- BLANK_CYCLES, 2, cycles with all digits off between digits (ghosting guard); 0 means no blank gap.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- load  in  1  capture request for bcd_in (single-cycle strobe or held).
- bcd_in  in  4*NUM_DIGITS  packed BCD digits; digit 0 = bits [3:0] = least significant.
- lz_en  in  1  leading-zero suppression enable.
- bcd_out  out  4  BCD nibble to the shared decoder; 4'hF = blank (decoder default = all segments off).
- digit_sel  out  NUM_DIGITS  one-hot, active-high digit enable; bit i lights digit i.
- frame_done  out  1  one-cycle pulse at the end of each full frame.
- pending  out  1  a loaded value is waiting to be applied.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, idx=0, cnt=0.
  - digit_sel=0, bcd_out=4'hF, frame_done=0, pending=0.
  - Display and pending registers cleared to 0.
- All outputs are registered and update on the same edge as the state/idx change.
- FSM states: IDLE, SCAN, BLANK.
  - IDLE: outputs blank (digit_sel=0, bcd_out=F). When en=1: apply pending value, then go to SCAN with idx=0, cnt=0.
  - SCAN: cnt counts 0..REFRESH_DIV-1. At REFRESH_DIV-1:
    - BLANK_CYCLES>0: go to BLANK, cnt=0.
    - BLANK_CYCLES=0: advance idx directly.
  - BLANK: digit_sel=0, bcd_out=F. cnt counts 0..BLANK_CYCLES-1, then advance idx and go to SCAN.
  - Advance idx: idx+1, or wrap from NUM_DIGITS-1 to 0.
  - On wrap: pulse frame_done for one cycle (coincident with the first cycle of digit 0) and apply pending value.
- SCAN outputs for digit idx:
  - Not suppressed: digit_sel = 1<<idx, bcd_out = disp[idx].
  - Suppressed: digit_sel=0, bcd_out=F.
- Frame period = NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Leading-zero suppression:
  - Applies when lz_en=1 and i>=1.
  - Digit i is suppressed if disp[i] and every higher digit equal 0.
  - Digit 0 is never suppressed.
  - Evaluated on the display register only, never the pending register.
- Load / apply:
  - load=1 captures bcd_in into the pending register; pending=1 from the next cycle.
  - Multiple loads before apply: last one wins.
  - Apply copies pending into the display register and clears pending. It occurs only at frame start (IDLE->SCAN or wrap to digit 0), so no frame mixes old and new digits.
  - load in the same cycle as an apply: that cycle's bcd_in goes straight to the display register; pending=0.
- en=0 in any state: next edge goes to IDLE, outputs blank, idx=0, cnt=0. The pending register is retained. Re-enabling restarts at digit 0.
- rst mid-frame: same as reset; the pending value is lost.
- Non-BCD nibbles (A..F) pass through unmodified; the decoder blanks them.
- Exactly zero or one bit of digit_sel is ever high.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
1. rst, load=1 with bcd_in=16'h1234, then en=1, lz_en=0 ->
   - sel=0001/bcd=4 for 4 cycles, then 1 blank cycle.
   - Then 0010/3, 0100/2, 1000/1.
   - frame_done pulses exactly every 20 cycles.
2. lz_en=1, load 16'h0050 -> frame shows digit0=0 (sel 0001), digit1=5 (sel 0010); digits 2,3 have sel=0, bcd=F. Load 16'h0000 -> only digit0 lit with 0.
3. Mid-frame load of 16'h9876 while digit2 is lit (display 16'h1234) ->
   - Digits 2,3 still show 2,1; pending=1.
   - From next frame: 6,7,8,9; pending=0 at apply edge.
4. Loads 16'h1111 then 16'h2222 within one frame -> next frame shows 2,2,2,2. A load landing exactly on the apply cycle -> value shown in that frame, pending stays 0.
5. Drop en during digit1 SCAN -> next edge sel=0, bcd=F, IDLE. Re-assert en -> digit0 shown first for a full 4 cycles. Assert rst mid-frame -> all outputs at reset values next edge, pending=0.
6. BLANK_CYCLES=0 build -> digit-to-digit transition with no sel=0 cycle; frame_done every 16 cycles. bcd_in nibble 4'hA -> bcd_out=A on that digit.
